// File: rtl/aes_inv_key_expand.sv
// AES-128 inverse key schedule. Walks round keys from round 10 back to round 0,
// one key per accepted handshake, using an external combinational SubWord S-box.
module aes_inv_key_expand (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [127:0] lastKey,
  input  logic         outReady,
  output logic [31:0]  subIn,
  input  logic [31:0]  subOut,
  output logic         busy,
  output logic         keyValid,
  output logic [127:0] roundKey,
  output logic [3:0]   roundIdx,
  output logic         done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         key_valid_q, key_valid_d;
  logic         done_q, done_d;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  p0_s, p1_s, p2_s, p3_s;
  logic         xfer_s;

  // Round constant used when the key of round idx was derived from round idx-1.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Undo one forward schedule step; P3 is the previous key's last word and
  // therefore the word whose RotWord fed SubWord in the forward direction.
  always_comb begin
    w0_s = round_key_q[127:96];
    w1_s = round_key_q[95:64];
    w2_s = round_key_q[63:32];
    w3_s = round_key_q[31:0];
    p3_s = w3_s ^ w2_s;
    p2_s = w2_s ^ w1_s;
    p1_s = w1_s ^ w0_s;
    p0_s = w0_s ^ subOut ^ {rcon(round_idx_q), 24'h000000};
  end

  assign subIn    = {p3_s[23:0], p3_s[31:24]};
  assign xfer_s   = key_valid_q & outReady;
  assign busy     = (state_q == RUN);
  assign keyValid = key_valid_q;
  assign roundKey = round_key_q;
  assign roundIdx = round_idx_q;
  assign done     = done_q;

  // Next-state logic: load on start, step back one round per transfer.
  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          round_key_d = lastKey;
          round_idx_d = 4'd10;
          key_valid_d = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (xfer_s) begin
          if (round_idx_q == 4'd0) begin
            key_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            round_key_d = {p0_s, p1_s, p2_s, p3_s};
            round_idx_d = round_idx_q - 4'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d     = IDLE;
        key_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      round_key_q <= 128'h0;
      round_idx_q <= 4'd0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Randomized bench for aes_inv_key_expand: S-box built from GF(2^8) arithmetic,
// reference reverse schedule computed on a 44-word array.
module tb_aes_inv_key_expand;
  logic         clk = 1'b0;
  logic         nReset;
  logic         start;
  logic [127:0] lastKey;
  logic         outReady;
  logic [31:0]  subIn;
  logic [31:0]  subOut;
  logic         busy;
  logic         keyValid;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_t [0:255];
  logic [7:0]   rc_t   [0:10];
  logic [127:0] exp_k  [0:10];
  logic [127:0] got_q  [$];

  localparam logic [127:0] VEC = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_inv_key_expand dut (
    .clk(clk), .nReset(nReset), .start(start), .lastKey(lastKey),
    .outReady(outReady), .subIn(subIn), .subOut(subOut), .busy(busy),
    .keyValid(keyValid), .roundKey(roundKey), .roundIdx(roundIdx), .done(done)
  );

  always #5 clk = ~clk;

  assign subOut = {sbox_t[subIn[31:24]], sbox_t[subIn[23:16]],
                   sbox_t[subIn[15:8]],  sbox_t[subIn[7:0]]};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15 - n -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc_t[0] = 8'h00;
    rc_t[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rc_t[r] = xtime(rc_t[r-1]);
  endtask

  // Reverse schedule: w[i] = w[i+4] ^ f(w[i+3]) from the round-10 words down.
  task automatic build_ref(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[40+j] = k[127-32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      t = w[i+3];
      if (i % 4 == 0) t = subword(rotword(t)) ^ {rc_t[i/4+1], 24'h000000};
      w[i] = w[i+4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] fwd(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int j = 0; j < 4; j++) w[j] = k0[127-32*j -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subword(rotword(t)) ^ {rc_t[i/4], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_exp(input logic [127:0] k);
    start    = 1'b1;
    lastKey  = k;
    outReady = 1'($urandom_range(1));
    @(negedge clk);
    start = 1'b0;
    build_ref(k);
  endtask

  // Follow one expansion from round 10 to done, with noise on start/lastKey.
  task automatic follow(input int pct, input int hold, input bit chain, input logic [127:0] nxt);
    int e = 10;
    int guard = 0;
    logic [6:0] ctl_exp;
    got_q.delete();
    while (e >= 0 && guard < 2000) begin
      ctl_exp = {4'(e), 3'b110};
      chk("key", roundKey, exp_k[e]);
      chk("ctl", 128'({roundIdx, keyValid, busy, done}), 128'(ctl_exp));
      chk("subin", 128'(subIn), 128'(rotword(exp_k[e][63:32] ^ exp_k[e][31:0])));
      outReady = (guard < hold) ? 1'b0 : ($urandom_range(99) < pct);
      start    = 1'($urandom_range(1));
      lastKey  = rnd128();
      if (outReady) got_q.push_back(roundKey);
      @(negedge clk);
      guard++;
      if (outReady) e--;
    end
    chk("timeout", 128'(guard < 2000), 128'(1));
    chk("done_ctl", 128'({roundIdx, keyValid, busy, done}), 128'(7'b0000_001));
    chk("done_key", roundKey, exp_k[0]);
    if (chain) begin
      start   = 1'b1;
      lastKey = nxt;
    end else begin
      start = 1'b0;
    end
    outReady = 1'($urandom_range(1));
    @(negedge clk);
    start = 1'b0;
    if (!chain) begin
      chk("idle_ctl", 128'({roundIdx, keyValid, busy, done}), 128'(7'b0));
      chk("idle_key", roundKey, exp_k[0]);
    end
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] nxt;
    bit ch;
    nReset = 1'b0; start = 1'b0; outReady = 1'b0; lastKey = 128'h0;
    build_tables();
    repeat (2) @(negedge clk);
    chk("rst_key", roundKey, 128'h0);
    chk("rst_ctl", 128'({roundIdx, keyValid, busy, done}), 128'(7'b0));
    chk("rst_subin", 128'(subIn), 128'h0);
    nReset = 1'b1;
    @(negedge clk);

    start_exp(VEC);
    follow(100, 0, 1'b0, 128'h0);
    chk("vec_count", 128'(got_q.size()), 128'(11));
    chk("vec_r10", got_q[0], VEC);
    chk("vec_r9", got_q[1], 128'hac7766f319fadc2128d12941575c006e);
    chk("vec_r0", got_q[10], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    start_exp(VEC);
    follow(100, 5, 1'b0, 128'h0);
    chk("hold_count", 128'(got_q.size()), 128'(11));
    chk("hold_r0", got_q[10], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    k = rnd128();
    start_exp(k);
    outReady = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_idx", 128'(roundIdx), 128'(4));
    chk("pre_rst_key", roundKey, exp_k[4]);
    #2 nReset = 1'b0;
    #1;
    chk("async_rst_key", roundKey, 128'h0);
    chk("async_rst_ctl", 128'({roundIdx, keyValid, busy, done}), 128'(7'b0));
    @(negedge clk);
    nReset = 1'b1;
    outReady = 1'b0;
    @(negedge clk);
    k = rnd128();
    start_exp(k);
    follow(100, 0, 1'b0, 128'h0);
    chk("post_rst_r10", got_q[0], k);

    k = rnd128();
    start_exp(k);
    for (int n = 0; n < 100; n++) begin
      nxt = rnd128();
      ch  = (n < 99) && ($urandom_range(1) == 1);
      follow(int'($urandom_range(100, 30)), 0, ch, nxt);
      chk("rand_count", 128'(got_q.size()), 128'(11));
      chk("rand_fwd", fwd(got_q[got_q.size()-1]), k);
      if (n < 99) begin
        k = nxt;
        if (ch) build_ref(k);
        else start_exp(k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_expand.md
AES_INV_KEY_EXPAND -- requirements
Module: aes_inv_key_expand

Interface
REQ-001 The block SHALL have no parameters; it SHALL be fixed to AES-128 (11 round keys, Nk=4).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 nReset  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request to begin reverse expansion; sampled only in IDLE.
REQ-005 lastKey  input  128  round-10 key; W0 = [127:96] ... W3 = [31:0].
REQ-006 outReady  input  1  consumer accepts roundKey when high together with keyValid.
REQ-007 subIn  output  32  word sent to the external 4-byte S-box (SubWord).
REQ-008 subOut  input  32  combinational SubWord(subIn) result, bytewise.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 keyValid  output  1  roundKey/roundIdx hold a valid key.
REQ-011 roundKey  output  128  current round key, same word order as lastKey.
REQ-012 roundIdx  output  4  round number of roundKey, from 10 down to 0.
REQ-013 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-014 States SHALL be IDLE and RUN.
REQ-015 IDLE with start=1: capture lastKey into roundKey, set roundIdx=10, keyValid=1, enter RUN on the same edge.
REQ-016 Latency: first key (round 10) valid on the cycle after start is sampled.
REQ-017 start in RUN SHALL be ignored; lastKey SHALL be sampled only on the accepting edge.
REQ-018 Handshake: a key is transferred on an edge where keyValid=1 and outReady=1.
REQ-019 While keyValid=1 and outReady=0, roundKey, roundIdx and keyValid SHALL hold unchanged for any number of cycles.
REQ-020 Previous-key computation from current words W0..W3 (combinational, registered on transfer):
- P3 = W3^W2
- P2 = W2^W1
- P1 = W1^W0
- P0 = W0 ^ subOut ^ {Rcon(roundIdx), 24'h0}
REQ-021 subIn SHALL equal RotWord(P3) = {P3[23:0], P3[31:24]} in every cycle, including IDLE.
REQ-022 Rcon(idx) for idx 1..10 = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex); Rcon(0)=00.
REQ-023 Transfer in RUN with roundIdx>0: roundKey <= {P0,P1,P2,P3}, roundIdx decrements by 1, keyValid stays 1 (throughput one key per cycle when outReady=1).
REQ-024 Transfer in RUN with roundIdx=0: keyValid <= 0, done <= 1 for exactly one cycle, return to IDLE; roundKey/roundIdx retain last values.
REQ-025 A start in the same cycle as done=1 SHALL be accepted (block is in IDLE).
REQ-026 roundIdx SHALL never wrap below 0 or exceed 10.

Reset
REQ-027 nReset low SHALL immediately force IDLE, busy=0, keyValid=0, done=0, roundKey=0, roundIdx=0, including mid-expansion.
REQ-028 After nReset deasserts, the first start SHALL begin a fresh expansion; no partial state SHALL survive.

Verification
REQ-029 lastKey=d014f9a8c9ee2589e13f0cc8b6630ca6, outReady=1 -> round 10 equals lastKey; round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; 11 consecutive valid cycles; done pulses once.
REQ-030 Same vector, outReady held low 5 cycles after start -> round 10 key held stable with keyValid=1 for all 5 cycles, then sequence continues unchanged.
REQ-031 Random outReady pattern over 100 expansions with random lastKey -> keys match a software reverse schedule; forward-expanding round 0 reproduces lastKey.
REQ-032 start pulsed while roundIdx=6 -> ignored; sequence continues 5..0 with no restart.
REQ-033 nReset asserted while roundIdx=4 -> all outputs 0 asynchronously; the next start yields round 10 = new lastKey.
REQ-034 start held high across done -> new expansion begins the cycle after done, with no lost or duplicated keys.
